serial_pattern_tx: RTL and testbench
====================================

# serial_pattern_tx

Serial pattern transmitter: captures a WIDTH-bit pattern on a start request and shifts it out MSB-first on a single-bit line, one bit per clock. It optionally repeats the pattern with a one-cycle idle gap between copies. It is the stimulus/driver end of the single-bit serial pattern interface; its `a` output feeds serial pattern detectors. It reports `busy`, `valid` and a `done` pulse. All outputs are Moore: decoded from state or taken directly from flops.

## Interface
- WIDTH, 8, pattern length in bits (≥2)
- CNT_W, 4, width of repeat count
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- stop  input  1  abort; sampled in SEND and GAP
- pattern  input  WIDTH  bits to send, MSB first; captured on accepted start
- repeats  input  CNT_W  extra copies; 0 = send once, k = k+1 copies; captured on accepted start
- a  output  1  serial data; idle level 1
- valid  output  1  high while `a` carries a pattern bit
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last bit of the last copy

## Operation
- States: IDLE, SEND, GAP, FINISH (2-bit enum).
- Reset (asynchronous) forces IDLE, shift reg = all-ones, bit_cnt = 0, rep_cnt = 0 → a=1, valid=0, busy=0, done=0.
- IDLE:
  - start=1 and stop=0 → load shreg and pat_hold with `pattern`, rep_cnt=`repeats`, bit_cnt=WIDTH-1 → SEND.
  - start and stop both high → stay IDLE; stop wins.
- SEND: a=shreg[WIDTH-1], valid=1. Each cycle shift left with fill bit 1; bit_cnt decrements.
  - bit_cnt==0 and rep_cnt==0 → FINISH.
  - bit_cnt==0 and rep_cnt>0 → rep_cnt decrements, shreg reloads from pat_hold, bit_cnt=WIDTH-1 → GAP.
- GAP: a=1, valid=0, one cycle only → SEND.
- FINISH: done=1, a=1, valid=0 → IDLE.
- stop=1 in SEND or GAP → IDLE next cycle, with no FINISH and no done. shreg is forced to all-ones so a=1 next cycle.
- start outside IDLE is ignored; no queuing. Changes to `pattern`/`repeats` after capture have no effect.
- Back-to-back: start may be high in the IDLE cycle immediately after FINISH.
- rep_cnt and bit_cnt never underflow; both are checked for zero before decrementing.

## Timing
- start sampled at edge 0 → first bit on `a` in cycle 1 (edge 0 to edge 1). Latency is 1 cycle.
- One copy occupies WIDTH cycles. Busy duration is (repeats+1)·WIDTH + repeats + 1 cycles, counting the GAP cycles plus FINISH.
- WIDTH=8, repeats=0: SEND cycles 1–8, done in cycle 9, IDLE in cycle 10. busy high in cycles 1–9.
- WIDTH=8, repeats=1: SEND 1–8, GAP 9, SEND 10–17, done 18.
- An asserted stop takes effect at the next edge: the bit on `a` in the stop cycle completes, then a=1.
- Reset mid-operation returns all outputs to reset values immediately, without waiting for an edge.

## Structure
- Shared package `pattern_pkg`:
  - `tx_state_t` enum (IDLE=2'b00, SEND=2'b01, GAP=2'b10, FINISH=2'b11)
  - constant IDLE_LEVEL=1'b1
- Sub-module `piso_shifter #(WIDTH)`:
  - parallel load, shift-left with fill, force-ones
  - output = MSB
  - contains no control logic
- Top level holds the FSM, pat_hold, bit_cnt ($clog2(WIDTH) bits) and rep_cnt (CNT_W bits).

## Test plan
- Reset check: assert reset mid-SEND (WIDTH=8, pattern=8'hA5) → a=1, valid=0, busy=0, done=0 immediately. Next start works normally.
- Single copy: pattern=8'b0100_1101, repeats=0, start at edge 0 → `a` = 0,1,0,0,1,1,0,1 in cycles 1–8, valid=1 in 1–8, done=1 in cycle 9 only.
- Repeats: pattern=8'hF0, repeats=2 → three copies of 1111_0000, each separated by one a=1/valid=0 cycle; done in cycle 27.
- Abort: start with pattern=8'h00, repeats=3, stop in cycle 5 → a=0 in cycles 1–5, a=1 and busy=0 from cycle 6, done never asserted.
- Contention:
  - start+stop together in IDLE → no transfer.
  - start pulses during SEND → ignored; transmitted bits unchanged.
  - `pattern` changed mid-send → no effect.
- Back-to-back: second start asserted in the IDLE cycle after done (pattern=8'h81) → first bit of the second transfer 1 cycle later, no extra idle cycles.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types and constants for the single-bit serial pattern interface.
package pattern_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SEND   = 2'b01,
      GAP    = 2'b10,
      FINISH = 2'b11
   } tx_state_t;

   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Request and serial-output signals of the pattern transmitter.
interface serial_pattern_tx_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
);

   logic             start;
   logic             stop;
   logic [WIDTH-1:0] pattern;
   logic [CNT_W-1:0] repeats;
   logic             a;
   logic             valid;
   logic             busy;
   logic             done;

   // Requester side: issues start/stop and consumes the serial stream.
   modport master (
      output start, stop, pattern, repeats,
      input  a, valid, busy, done
   );

   // Transmitter side.
   modport slave (
      input  start, stop, pattern, repeats,
      output a, valid, busy, done
   );

endinterface

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shift register, MSB first; resets and forces to the idle level.
module piso_shifter
   import pattern_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             shift,
   input  logic             force_ones,
   output logic             msb
);

   logic [WIDTH-1:0] shreg_q, shreg_d;

   // force_ones has priority so an abort always parks the line at the idle level.
   always_comb begin
      shreg_d = shreg_q;
      if (force_ones) begin
         shreg_d = {WIDTH{IDLE_LEVEL}};
      end else if (load) begin
         shreg_d = load_val;
      end else if (shift) begin
         shreg_d = {shreg_q[WIDTH-2:0], IDLE_LEVEL};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_q <= {WIDTH{IDLE_LEVEL}};
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, optionally repeated
// with a one-cycle idle gap between copies. All outputs are Moore.
module serial_pattern_tx
   import pattern_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   serial_pattern_tx_if.slave  bus
);

   localparam int unsigned BitW = $clog2(WIDTH);
   localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

   tx_state_t        state_q, state_d;
   logic [WIDTH-1:0] pat_hold_q, pat_hold_d;
   logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;

   logic             sh_load;
   logic [WIDTH-1:0] sh_load_val;
   logic             sh_shift;
   logic             sh_force;
   logic             sh_msb;

   piso_shifter #(
      .WIDTH (WIDTH)
   ) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .load       (sh_load),
      .load_val   (sh_load_val),
      .shift      (sh_shift),
      .force_ones (sh_force),
      .msb        (sh_msb)
   );

   always_comb begin
      state_d     = state_q;
      pat_hold_d  = pat_hold_q;
      bit_cnt_d   = bit_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      sh_load     = 1'b0;
      sh_load_val = pat_hold_q;
      sh_shift    = 1'b0;
      sh_force    = 1'b0;

      unique case (state_q)
         IDLE: begin
            // stop wins over a simultaneous start
            if (bus.start && !bus.stop) begin
               sh_load     = 1'b1;
               sh_load_val = bus.pattern;
               pat_hold_d  = bus.pattern;
               rep_cnt_d   = bus.repeats;
               bit_cnt_d   = LastBit;
               state_d     = SEND;
            end
         end
         SEND: begin
            if (bus.stop) begin
               sh_force = 1'b1;
               state_d  = IDLE;
            end else if (bit_cnt_q != '0) begin
               sh_shift  = 1'b1;
               bit_cnt_d = bit_cnt_q - BitW'(1);
            end else if (rep_cnt_q != '0) begin
               // Reload now so the next copy is ready when GAP ends.
               sh_load   = 1'b1;
               rep_cnt_d = rep_cnt_q - CNT_W'(1);
               bit_cnt_d = LastBit;
               state_d   = GAP;
            end else begin
               sh_shift = 1'b1;
               state_d  = FINISH;
            end
         end
         GAP: begin
            if (bus.stop) begin
               sh_force = 1'b1;
               state_d  = IDLE;
            end else begin
               state_d = SEND;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pat_hold_q <= '0;
         bit_cnt_q  <= '0;
         rep_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         pat_hold_q <= pat_hold_d;
         bit_cnt_q  <= bit_cnt_d;
         rep_cnt_q  <= rep_cnt_d;
      end
   end

   assign bus.a     = (state_q == SEND) ? sh_msb : IDLE_LEVEL;
   assign bus.valid = (state_q == SEND);
   assign bus.busy  = (state_q != IDLE);
   assign bus.done  = (state_q == FINISH);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed self-checking bench for serial_pattern_tx (WIDTH=8, CNT_W=4).
module tb_serial_pattern_tx;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   serial_pattern_tx_if #(.WIDTH(8), .CNT_W(4)) bus ();

   serial_pattern_tx #(
      .WIDTH (8),
      .CNT_W (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to the next cycle; sampling and driving happen 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] pat;
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.pattern = 8'h00;
      bus.repeats = 4'd0;
      #2;
      n_checks++;
      if ({bus.a, bus.valid, bus.busy, bus.done} !== 4'b1000) begin
         $display("FAIL reset_init got a/v/b/d=%b exp 1000", {bus.a, bus.valid, bus.busy, bus.done});
         n_fail++;
      end
      tick();
      tick();
      reset = 1'b0;
      tick();
      // Reset mid-send must clear outputs without waiting for an edge.
      bus.start   = 1'b1;
      bus.pattern = 8'hA5;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      n_checks++;
      if (bus.busy !== 1'b1) begin
         $display("FAIL reset_presend_busy got %b exp 1", bus.busy);
         n_fail++;
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.a, bus.valid, bus.busy, bus.done} !== 4'b1000) begin
         $display("FAIL reset_async got a/v/b/d=%b exp 1000", {bus.a, bus.valid, bus.busy, bus.done});
         n_fail++;
      end
      tick();
      reset = 1'b0;
      tick();
      pat         = 8'b1010_0101;
      bus.start   = 1'b1;
      bus.pattern = 8'hA5;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         n_checks++;
         if (bus.a !== ((c <= 8) ? pat[8-c] : 1'b1) || bus.done !== (c == 9)) begin
            $display("FAIL reset_resume c%0d got a=%b done=%b", c, bus.a, bus.done);
            n_fail++;
         end
         tick();
      end
   endtask

   task automatic test_single();
      logic [7:0] pat;
      logic       ea;
      pat         = 8'b0100_1101;
      bus.pattern = pat;
      bus.repeats = 4'd0;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         ea = (c <= 8) ? pat[8-c] : 1'b1;
         n_checks++;
         if (bus.a !== ea || bus.valid !== (c <= 8) || bus.done !== (c == 9)
             || bus.busy !== (c <= 9)) begin
            $display("FAIL single c%0d got a/v/b/d=%b%b%b%b exp a=%b v=%b b=%b d=%b", c,
                     bus.a, bus.valid, bus.busy, bus.done, ea, c <= 8, c <= 9, c == 9);
            n_fail++;
         end
         tick();
      end
   endtask

   task automatic test_repeats();
      logic [7:0] pat;
      logic       ea, ev;
      int         p;
      pat         = 8'hF0;
      bus.pattern = pat;
      bus.repeats = 4'd2;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 29; c++) begin
         p  = (c - 1) % 9;
         ev = (c <= 26) && (p < 8);
         ea = ev ? pat[7-p] : 1'b1;
         n_checks++;
         if (bus.a !== ea || bus.valid !== ev || bus.done !== (c == 27)
             || bus.busy !== (c <= 27)) begin
            $display("FAIL repeats c%0d got a/v/b/d=%b%b%b%b exp a=%b v=%b b=%b d=%b", c,
                     bus.a, bus.valid, bus.busy, bus.done, ea, ev, c <= 27, c == 27);
            n_fail++;
         end
         tick();
      end
   endtask

   task automatic test_abort();
      bus.pattern = 8'h00;
      bus.repeats = 4'd3;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         bus.stop = (c == 5);
         n_checks++;
         if (c <= 5) begin
            if (bus.a !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
               $display("FAIL abort_send c%0d got a=%b busy=%b done=%b exp 0 1 0", c, bus.a,
                        bus.busy, bus.done);
               n_fail++;
            end
         end else if (bus.a !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL abort_idle c%0d got a=%b busy=%b done=%b exp 1 0 0", c, bus.a,
                     bus.busy, bus.done);
            n_fail++;
         end
         tick();
      end
      bus.stop = 1'b0;
   endtask

   task automatic test_contention();
      logic [7:0] pat;
      bus.pattern = 8'hC3;
      bus.repeats = 4'd0;
      bus.start   = 1'b1;
      bus.stop    = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         n_checks++;
         if (bus.busy !== 1'b0 || bus.a !== 1'b1) begin
            $display("FAIL start_stop_idle c%0d got busy=%b a=%b exp 0 1", c, bus.busy, bus.a);
            n_fail++;
         end
         tick();
      end
      pat         = 8'b0011_1100;
      bus.pattern = 8'h3C;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (c == 2) bus.pattern = 8'h00;
         bus.start = (c == 3) || (c == 6);
         if (bus.start) begin
            bus.pattern = 8'hFF;
            bus.repeats = 4'd5;
         end
         n_checks++;
         if (bus.a !== ((c <= 8) ? pat[8-c] : 1'b1) || bus.done !== (c == 9)
             || bus.busy !== (c <= 9)) begin
            $display("FAIL contention c%0d got a=%b done=%b busy=%b", c, bus.a, bus.done,
                     bus.busy);
            n_fail++;
         end
         tick();
      end
      bus.repeats = 4'd0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat1, pat2;
      logic       ea;
      pat1        = 8'b0101_0101;
      pat2        = 8'b1000_0001;
      bus.pattern = pat1;
      bus.repeats = 4'd0;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         if (c == 10) begin
            bus.start   = 1'b1;
            bus.pattern = 8'h81;
         end else begin
            bus.start = 1'b0;
         end
         if (c <= 8) ea = pat1[8-c];
         else if (c >= 11 && c <= 18) ea = pat2[18-c];
         else ea = 1'b1;
         n_checks++;
         if (bus.a !== ea || bus.done !== (c == 9 || c == 19)
             || bus.busy !== (c != 10)) begin
            $display("FAIL back_to_back c%0d got a=%b done=%b busy=%b exp a=%b", c, bus.a,
                     bus.done, bus.busy, ea);
            n_fail++;
         end
         tick();
      end
      bus.start = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single();
      test_repeats();
      test_abort();
      test_contention();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
